// File: rtl/epu_pingpong_ctrl_if.sv
// Control-side bundle between the ping-pong layer sequencer and its CPU/DMA/EPU/switcher peers.
// master = sequencer, slave = everything it talks to.
interface epu_pingpong_ctrl_if #(
    parameter int LAYER_W = 5
) ();
    logic               start_i;
    logic               abort_i;
    logic [LAYER_W-1:0] num_layers_i;
    logic               ld_req_o;
    logic               ld_done_i;
    logic               epu_start_o;
    logic               epu_done_i;
    logic               inout_trans_o;
    logic [LAYER_W-1:0] cur_layer_o;
    logic               st_req_o;
    logic               result_sel_o;
    logic               st_done_i;
    logic               busy_o;
    logic               done_o;

    modport master (
        input  start_i, abort_i, num_layers_i, ld_done_i, epu_done_i, st_done_i,
        output ld_req_o, epu_start_o, inout_trans_o, cur_layer_o,
               st_req_o, result_sel_o, busy_o, done_o
    );

    modport slave (
        output start_i, abort_i, num_layers_i, ld_done_i, epu_done_i, st_done_i,
        input  ld_req_o, epu_start_o, inout_trans_o, cur_layer_o,
               st_req_o, result_sel_o, busy_o, done_o
    );
endinterface

// File: rtl/epu_pingpong_ctrl.sv
// Layer sequencer for the EPU ping-pong buffer pair: preload, run each layer, swap, store.
// Latency: every input handshake takes effect one cycle later; layer-to-layer start gap is 2 cycles.
// Backpressure: waits indefinitely on ld_done/epu_done/st_done pulses; abort returns to idle.
module epu_pingpong_ctrl #(
    parameter int LAYER_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    epu_pingpong_ctrl_if.master io
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_SWAP,
        S_STORE,
        S_DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [LAYER_W-1:0] n_lyr_q,     n_lyr_d;
    logic [LAYER_W-1:0] cur_layer_q, cur_layer_d;
    logic               trans_q,     trans_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_lyr_q     <= '0;
            cur_layer_q <= '0;
            trans_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_lyr_q     <= n_lyr_d;
            cur_layer_q <= cur_layer_d;
            trans_q     <= trans_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        n_lyr_d     = n_lyr_q;
        cur_layer_d = cur_layer_q;
        trans_d     = trans_q;

        case (state_q)
            S_IDLE: begin
                if (io.start_i) begin
                    n_lyr_d     = io.num_layers_i;
                    cur_layer_d = '0;
                    state_d     = (io.num_layers_i == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (io.ld_done_i) state_d = S_RUN;
            end
            S_RUN: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (io.epu_done_i) begin
                    state_d = (cur_layer_q == n_lyr_q - LAYER_W'(1)) ? S_STORE : S_SWAP;
                end
            end
            S_SWAP: begin
                // One settled cycle for the switcher before the next layer's start.
                trans_d     = ~trans_q;
                cur_layer_d = cur_layer_q + LAYER_W'(1);
                state_d     = S_RUN;
            end
            S_STORE: begin
                if (io.st_done_i) state_d = S_DONE;
            end
            S_DONE: begin
                trans_d     = 1'b0;
                cur_layer_d = '0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (io.abort_i && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            trans_d     = 1'b0;
            cur_layer_d = '0;
        end
    end

    assign io.ld_req_o      = (state_q == S_LOAD);
    assign io.epu_start_o   = (state_q == S_RUN);
    assign io.st_req_o      = (state_q == S_STORE);
    assign io.result_sel_o  = (state_q == S_STORE) && trans_q;
    assign io.busy_o        = (state_q != S_IDLE);
    assign io.done_o        = (state_q == S_DONE);
    assign io.inout_trans_o = trans_q;
    assign io.cur_layer_o   = cur_layer_q;

endmodule

// File: tb/tb_epu_pingpong_ctrl.sv
// Directed bench for the ping-pong layer sequencer with a scoreboard of expected EPU starts,
// store buffer selections and job completions.
module tb_epu_pingpong_ctrl;

    localparam int LAYER_W = 5;

    logic clk;
    logic rst;

    epu_pingpong_ctrl_if #(.LAYER_W(LAYER_W)) ifc ();

    epu_pingpong_ctrl #(.LAYER_W(LAYER_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // [5] = expected inout_trans, [4:0] = expected cur_layer at each epu_start pulse
    logic [5:0] exp_start [$];
    logic       exp_sel   [$];
    logic       exp_done  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic st_prev = 1'b0;
    logic [5:0] e_start;
    always @(negedge clk) begin
        if (ifc.epu_start_o) begin
            if (exp_start.size() == 0) begin
                check("sb_unexp_start", ifc.epu_start_o, 1'b0);
            end else begin
                e_start = exp_start.pop_front();
                check("sb_start_trans", ifc.inout_trans_o, e_start[5]);
                check("sb_start_layer", ifc.cur_layer_o, e_start[4:0]);
            end
        end
        if (ifc.st_req_o && !st_prev) begin
            if (exp_sel.size() == 0) begin
                check("sb_unexp_store", ifc.st_req_o, 1'b0);
            end else begin
                check("sb_result_sel", ifc.result_sel_o, exp_sel.pop_front());
            end
        end
        st_prev = ifc.st_req_o;
        if (ifc.done_o) begin
            if (exp_done.size() == 0) check("sb_unexp_done", ifc.done_o, 1'b0);
            else void'(exp_done.pop_front());
        end
    end

    task automatic run_job(input int n, input bit spur, input bit abort_with_start);
        for (int i = 0; i < n; i++) exp_start.push_back({i[0], i[4:0]});
        if (n > 0) exp_sel.push_back(n[0] == 1'b0);
        exp_done.push_back(1'b1);

        ifc.num_layers_i = n[LAYER_W-1:0];
        ifc.start_i      = 1'b1;
        ifc.abort_i      = abort_with_start;
        cyc();
        ifc.start_i = 1'b0;
        ifc.abort_i = 1'b0;

        if (n == 0) begin
            check("zero_done", ifc.done_o, 1'b1);
            check("zero_ld_req", ifc.ld_req_o, 1'b0);
            cyc();
            check("zero_idle_busy", ifc.busy_o, 1'b0);
            check("zero_done_clr", ifc.done_o, 1'b0);
            return;
        end

        check("ld_req_lat", ifc.ld_req_o, 1'b1);
        check("busy_load", ifc.busy_o, 1'b1);
        if (spur) begin
            ifc.epu_done_i = 1'b1;
            ifc.st_done_i  = 1'b1;
            cyc();
            ifc.epu_done_i = 1'b0;
            ifc.st_done_i  = 1'b0;
            check("spur_load_ld_req", ifc.ld_req_o, 1'b1);
            check("spur_load_start", ifc.epu_start_o, 1'b0);
        end
        cyc();
        check("ld_req_hold", ifc.ld_req_o, 1'b1);
        ifc.ld_done_i = 1'b1;
        cyc();
        ifc.ld_done_i = 1'b0;
        check("start_after_ld", ifc.epu_start_o, 1'b1);

        for (int i = 0; i < n; i++) begin
            check("run_layer", ifc.cur_layer_o, i[LAYER_W-1:0]);
            check("run_trans", ifc.inout_trans_o, i[0]);
            cyc();
            check("start_pulse_len", ifc.epu_start_o, 1'b0);
            if (spur && i == 0) begin
                ifc.start_i      = 1'b1;
                ifc.num_layers_i = 5'd7;
                cyc();
                ifc.start_i = 1'b0;
                check("spur_wait_start", ifc.epu_start_o, 1'b0);
                check("spur_wait_ldreq", ifc.ld_req_o, 1'b0);
            end
            cyc();
            ifc.epu_done_i = 1'b1;
            cyc();
            ifc.epu_done_i = 1'b0;
            if (i < n - 1) begin
                check("swap_no_start", ifc.epu_start_o, 1'b0);
                cyc();
                check("next_start_lat", ifc.epu_start_o, 1'b1);
            end else begin
                check("st_req_lat", ifc.st_req_o, 1'b1);
                check("store_sel", ifc.result_sel_o, (n % 2) == 0);
            end
        end

        cyc();
        check("st_req_hold", ifc.st_req_o, 1'b1);
        ifc.st_done_i = 1'b1;
        cyc();
        ifc.st_done_i = 1'b0;
        check("done_lat", ifc.done_o, 1'b1);
        check("done_st_req_off", ifc.st_req_o, 1'b0);
        cyc();
        check("done_one_cycle", ifc.done_o, 1'b0);
        check("idle_busy", ifc.busy_o, 1'b0);
        check("idle_trans", ifc.inout_trans_o, 1'b0);
        check("idle_layer", ifc.cur_layer_o, '0);
    endtask

    task automatic abort_job(input bit use_rst);
        exp_start.push_back({1'b0, 5'd0});
        exp_start.push_back({1'b1, 5'd1});
        ifc.num_layers_i = 5'd3;
        ifc.start_i      = 1'b1;
        cyc();
        ifc.start_i   = 1'b0;
        ifc.ld_done_i = 1'b1;
        cyc();
        ifc.ld_done_i = 1'b0;
        cyc();
        ifc.epu_done_i = 1'b1;
        cyc();
        ifc.epu_done_i = 1'b0;
        cyc();
        check("ab_run1_trans", ifc.inout_trans_o, 1'b1);
        cyc();
        check("ab_wait1_busy", ifc.busy_o, 1'b1);
        if (use_rst) rst = 1'b1;
        else         ifc.abort_i = 1'b1;
        cyc();
        rst         = 1'b0;
        ifc.abort_i = 1'b0;
        check("ab_busy", ifc.busy_o, 1'b0);
        check("ab_trans", ifc.inout_trans_o, 1'b0);
        check("ab_layer", ifc.cur_layer_o, '0);
        check("ab_no_done", ifc.done_o, 1'b0);
        cyc();
        check("ab_no_done_late", ifc.done_o, 1'b0);
        check("ab_stay_idle", ifc.busy_o, 1'b0);
    endtask

    initial begin
        rst              = 1'b1;
        ifc.start_i      = 1'b0;
        ifc.abort_i      = 1'b0;
        ifc.num_layers_i = '0;
        ifc.ld_done_i    = 1'b0;
        ifc.epu_done_i   = 1'b0;
        ifc.st_done_i    = 1'b0;
        repeat (3) cyc();

        check("rst_ld_req", ifc.ld_req_o, 1'b0);
        check("rst_epu_start", ifc.epu_start_o, 1'b0);
        check("rst_trans", ifc.inout_trans_o, 1'b0);
        check("rst_layer", ifc.cur_layer_o, '0);
        check("rst_st_req", ifc.st_req_o, 1'b0);
        check("rst_sel", ifc.result_sel_o, 1'b0);
        check("rst_busy", ifc.busy_o, 1'b0);
        check("rst_done", ifc.done_o, 1'b0);
        rst = 1'b0;
        cyc();

        // Stray handshakes and abort while idle must leave the block idle.
        ifc.ld_done_i  = 1'b1;
        ifc.epu_done_i = 1'b1;
        ifc.st_done_i  = 1'b1;
        ifc.abort_i    = 1'b1;
        cyc();
        ifc.ld_done_i  = 1'b0;
        ifc.epu_done_i = 1'b0;
        ifc.st_done_i  = 1'b0;
        ifc.abort_i    = 1'b0;
        check("idle_spur_busy", ifc.busy_o, 1'b0);

        run_job(1, 1'b0, 1'b0);
        run_job(3, 1'b0, 1'b0);
        run_job(2, 1'b0, 1'b0);
        run_job(0, 1'b0, 1'b0);
        run_job(3, 1'b1, 1'b0);
        abort_job(1'b0);
        abort_job(1'b1);
        run_job(3, 1'b0, 1'b0);
        run_job(1, 1'b0, 1'b1);
        run_job(31, 1'b0, 1'b0);
        cyc();

        check("sb_start_drain", exp_start.size(), 0);
        check("sb_sel_drain", exp_sel.size(), 0);
        check("sb_done_drain", exp_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
